// File: rtl/matrix_row_gen_pkg.sv
// -----------------------------------------------------------------------------
// matrix_row_gen_pkg
// Shared definitions for the 3-row tap generator and the 3x3 matrix blocks
// that consume its output.
//   - Default picture geometry and pixel width.
//   - cnt_w(): counter width for a given count, never narrower than 1 bit.
//   - Column/row counter widths for the default geometry.
// -----------------------------------------------------------------------------
package matrix_row_gen_pkg;

    localparam int PIC_WIDTH_DEF  = 250;
    localparam int PIC_HEIGHT_DEF = 250;
    localparam int WIDTH_DEF      = 24;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W_DEF = cnt_w(PIC_WIDTH_DEF);
    localparam int ROW_W_DEF = cnt_w(PIC_HEIGHT_DEF);

endpackage

// File: rtl/matrix_row_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image row of storage, indexed by column.
// Reads are combinational and writes are synchronous. A write and a read at
// the same address in the same cycle therefore return the old contents
// (read-before-write). Contents are never reset.
// Ports:
//   clk     input  clock, rising edge
//   i_we    input  write enable
//   i_addr  input  column address (read and write)
//   i_din   input  write data
//   o_dout  output data currently stored at i_addr
// -----------------------------------------------------------------------------
module line_buffer
    import matrix_row_gen_pkg::*;
#(
    parameter int DEPTH  = PIC_WIDTH_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_din,
    output logic [WIDTH-1:0]  o_dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_dout = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
    end

endmodule

// File: rtl/matrix_row_gen.sv
// -----------------------------------------------------------------------------
// matrix_row_gen
// Streaming 3-row tap generator. For each accepted pixel it emits one column
// of three vertically aligned pixels, one cycle later:
//   dout1 = (row-2, col)   dout2 = (row-1, col)   dout3 = (row, col)
// The two previous rows are held in two line buffers. lb1 holds the previous
// row. lb2 holds the row before that and is refilled from lb1's old contents.
// Build option:
//   BORDER_REPLICATE_EN  When defined, rows 0 and 1 are also emitted, with the
//                        missing rows above the image replaced by the topmost
//                        available row.
// Ports:
//   clk        input   clock, rising edge
//   rst_n      input   asynchronous reset, active low
//   valid_in   input   din carries a pixel this cycle
//   sof        input   start of frame (qualified by valid_in)
//   din        input   pixel, raster order
//   valid_out  output  dout1..dout3 valid
//   dout1..3   output  top / middle / current row taps
//   frame_end  output  pulse alongside the output of the last pixel of a frame
// -----------------------------------------------------------------------------
module matrix_row_gen
    import matrix_row_gen_pkg::*;
#(
    parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
    parameter int PIC_HEIGHT = PIC_HEIGHT_DEF,
    parameter int WIDTH      = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             sof,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             frame_end
);

    localparam int COL_W = cnt_w(PIC_WIDTH);
    localparam int ROW_W = cnt_w(PIC_HEIGHT);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // Position of the pixel on din. sof forces it to (0,0) whatever the
    // counters hold, so a misaligned source resynchronises on the next frame.
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_last_col;
    logic             w_last_row;
    logic [WIDTH-1:0] w_lb1_q;
    logic [WIDTH-1:0] w_lb2_q;

    always_comb begin
        w_col      = sof ? '0 : r_col;
        w_row      = sof ? '0 : r_row;
        w_last_col = (w_col == COL_W'(PIC_WIDTH - 1));
        w_last_row = (w_row == ROW_W'(PIC_HEIGHT - 1));
    end

    line_buffer #(
        .DEPTH  (PIC_WIDTH),
        .WIDTH  (WIDTH),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk    (clk),
        .i_we   (valid_in),
        .i_addr (w_col),
        .i_din  (din),
        .o_dout (w_lb1_q)
    );

    line_buffer #(
        .DEPTH  (PIC_WIDTH),
        .WIDTH  (WIDTH),
        .ADDR_W (COL_W)
    ) u_lb2 (
        .clk    (clk),
        .i_we   (valid_in),
        .i_addr (w_col),
        .i_din  (w_lb1_q),
        .o_dout (w_lb2_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            valid_out <= 1'b0;
            frame_end <= 1'b0;
            dout1     <= '0;
            dout2     <= '0;
            dout3     <= '0;
        end else if (valid_in) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + ROW_W'(1);
            end else begin
                r_col <= w_col + COL_W'(1);
                r_row <= w_row;
            end

            frame_end <= w_last_col && w_last_row;
            dout3     <= din;
`ifdef BORDER_REPLICATE_EN
            valid_out <= 1'b1;
            if (w_row == '0) begin
                dout2 <= din;
                dout1 <= din;
            end else if (w_row == ROW_W'(1)) begin
                // Row 0 stands in for the missing row above it.
                dout2 <= w_lb1_q;
                dout1 <= w_lb1_q;
            end else begin
                dout2 <= w_lb1_q;
                dout1 <= w_lb2_q;
            end
`else
            valid_out <= (w_row >= ROW_W'(2));
            dout2     <= w_lb1_q;
            dout1     <= w_lb2_q;
`endif
        end else begin
            // Idle input: taps hold, strobes drop.
            valid_out <= 1'b0;
            frame_end <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_row_gen.sv
// -----------------------------------------------------------------------------
// tb_matrix_row_gen
// Scoreboard bench for matrix_row_gen on a 4x4 picture. Each pixel carries the
// value row*16+col of the raster position the bench assigns it. The expected
// output is derived from that position and pushed when the pixel is driven,
// then popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_matrix_row_gen;

    localparam int PW = 4;
    localparam int PH = 4;
    localparam int W  = 24;

    logic         clk;
    logic         rst_n;
    logic         valid_in;
    logic         sof;
    logic [W-1:0] din;
    logic         valid_out;
    logic [W-1:0] dout1;
    logic [W-1:0] dout2;
    logic [W-1:0] dout3;
    logic         frame_end;

    matrix_row_gen #(
        .PIC_WIDTH  (PW),
        .PIC_HEIGHT (PH),
        .WIDTH      (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .sof       (sof),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .frame_end (frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           vld;
        bit           fe;
        bit           chk_d12;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] d3;
        string        tag;
    } exp_t;

    exp_t sb_q[$];

    // Last output the bench can vouch for, used for the hold checks.
    logic [W-1:0] m_d1;
    logic [W-1:0] m_d2;
    logic [W-1:0] m_d3;
    bit           m_known12;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb_q.pop_front();
        check_val({e.tag, " valid_out"}, 32'(valid_out), 32'(e.vld));
        check_val({e.tag, " frame_end"}, 32'(frame_end), 32'(e.fe));
        check_val({e.tag, " dout3"}, 32'(dout3), 32'(e.d3));
        if (e.chk_d12) begin
            check_val({e.tag, " dout2"}, 32'(dout2), 32'(e.d2));
            check_val({e.tag, " dout1"}, 32'(dout1), 32'(e.d1));
        end
    endtask

    task automatic drive_px(input int r, input int c, input bit s);
        exp_t         e;
        logic [W-1:0] px;
        px = W'(r * 16 + c);
        @(negedge clk);
        valid_in = 1'b1;
        sof      = s;
        din      = px;
        e.tag    = $sformatf("px%0d%0d", r, c);
        e.fe     = (r == PH - 1) && (c == PW - 1);
        e.d3     = px;
`ifdef BORDER_REPLICATE_EN
        e.vld     = 1'b1;
        e.chk_d12 = 1'b1;
        if (r == 0) begin
            e.d1 = px;
            e.d2 = px;
        end else if (r == 1) begin
            e.d1 = px - W'(16);
            e.d2 = px - W'(16);
        end else begin
            e.d1 = px - W'(32);
            e.d2 = px - W'(16);
        end
`else
        e.vld     = (r >= 2);
        e.chk_d12 = (r >= 2);
        e.d1      = px - W'(32);
        e.d2      = px - W'(16);
`endif
        m_d1      = e.d1;
        m_d2      = e.d2;
        m_d3      = e.d3;
        m_known12 = e.chk_d12;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle_cycle();
        exp_t e;
        @(negedge clk);
        valid_in  = 1'b0;
        sof       = 1'b0;
        e.tag     = "gap";
        e.vld     = 1'b0;
        e.fe      = 1'b0;
        e.chk_d12 = m_known12;
        e.d1      = m_d1;
        e.d2      = m_d2;
        e.d3      = m_d3;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Drive raster positions (r0,c0)..(r1,c1) inclusive.
    task automatic drive_range(input int r0, input int c0, input int r1, input int c1);
        for (int idx = r0 * PW + c0; idx <= r1 * PW + c1; idx++) begin
            drive_px(idx / PW, idx % PW, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, " valid_out"}, 32'(valid_out), 32'd0);
        check_val({tag, " frame_end"}, 32'(frame_end), 32'd0);
        check_val({tag, " dout1"}, 32'(dout1), 32'd0);
        check_val({tag, " dout2"}, 32'(dout2), 32'd0);
        check_val({tag, " dout3"}, 32'(dout3), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        valid_in  = 1'b0;
        sof       = 1'b0;
        din       = '0;
        m_d1      = '0;
        m_d2      = '0;
        m_d3      = '0;
        m_known12 = 1'b1;
        #2;
        rst_n = 1'b0;
        #5;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: continuous.
        drive_range(0, 0, 3, 3);

        // Frame 2: 3-cycle gap between 0x21 and 0x22.
        drive_range(0, 0, 2, 1);
        repeat (3) idle_cycle();
        drive_range(2, 2, 3, 3);

        // Frame 3: sof arrives while the counters sit at (1,2).
        drive_range(0, 0, 1, 1);
        drive_px(0, 0, 1'b1);
        drive_range(0, 1, 3, 3);

        // Frame 4: asynchronous reset after 0x21.
        drive_range(0, 0, 2, 1);
        @(negedge clk);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        m_d1      = '0;
        m_d2      = '0;
        m_d3      = '0;
        m_known12 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drive_range(0, 0, 3, 3);

        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
